// File: rtl/flop_write_arbiter.sv
// flop_write_arbiter: round-robin arbiter that grants one requester at a time
// write access to a shared enabled register. A granted requester may keep
// the grant for up to MAXBURST consecutive writes by holding lock. Every
// grant is followed by at least one idle arbitration cycle.
module flop_write_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy,
    output logic                     en,
    output logic [WIDTH-1:0]         d
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nx;
    logic [NREQ-1:0]  gnt_nx;
    logic [IDW-1:0]   gnt_id_nx;
    logic [IDW-1:0]   ptr, ptr_nx;
    logic [CW-1:0]    burst_cnt, burst_cnt_nx;
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

    // Find the first requesting index at or above ptr, wrapping modulo NREQ;
    // scanning offsets from high to low lets the smallest offset win.
    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = 0;
        sel        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IDW'(idx);
            if (req[sel]) begin
                pick_valid = 1'b1;
                pick_id    = sel;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, extend or release the burst in GRANT.
    always_comb begin
        state_nx     = state;
        gnt_nx       = gnt;
        gnt_id_nx    = gnt_id;
        ptr_nx       = ptr;
        burst_cnt_nx = burst_cnt;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (pick_valid) begin
                    gnt_nx       = NREQ'(1) << pick_id;
                    gnt_id_nx    = pick_id;
                    burst_cnt_nx = CW'(1);
                    state_nx     = GRANT;
                end
            end
            GRANT: begin
                if (req[gnt_id] && lock[gnt_id] && (burst_cnt < CW'(MAXBURST))) begin
                    burst_cnt_nx = burst_cnt + CW'(1);
                end else begin
                    gnt_nx       = '0;
                    burst_cnt_nx = '0;
                    state_nx     = IDLE;
                    if (gnt_id == IDW'(NREQ - 1)) begin
                        ptr_nx = '0;
                    end else begin
                        ptr_nx = gnt_id + IDW'(1);
                    end
                end
            end
            default: begin
                gnt_nx       = '0;
                burst_cnt_nx = '0;
                state_nx     = IDLE;
            end
        endcase
    end

    // State register; reset drops any grant in flight immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            ptr       <= ptr_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    // Write data steered by the registered one-hot grant; zero when idle.
    always_comb begin
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                d = d | wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign en   = |gnt;
    assign busy = (state == GRANT);

endmodule

// File: doc/flop_write_arbiter.md
FLOP_WRITE_ARBITER -- requirements
Module: flop_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared register and of each requester's write data.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter MAXBURST, default 4: maximum consecutive writes per grant; legal range 1..16.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NREQ  per-requester write request; held high until granted.
REQ-008 lock  input  NREQ  per-requester burst request; meaningful only while that requester is granted.
REQ-009 wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 gnt  output  NREQ  one-hot grant; wdata[i] is written at the end of every cycle gnt[i] is high.
REQ-011 gnt_id  output  clog2(NREQ)  binary index of the current or most recent grant.
REQ-012 busy  output  1  high while in state GRANT.
REQ-013 en  output  1  write enable to the shared enabled register.
REQ-014 d  output  WIDTH  write data to the shared enabled register.

Function
REQ-015 The state machine SHALL have two states, IDLE and GRANT; it resets to IDLE.
REQ-016 In IDLE with any req bit high, the block SHALL select the first requester at or above the rotate pointer ptr, wrapping modulo NREQ. It SHALL then register that requester into gnt, load gnt_id, set the burst count to 1, and enter GRANT.
REQ-017 In IDLE with req all zero, gnt SHALL stay zero and the state SHALL stay IDLE.
REQ-018 en SHALL equal OR-reduce(gnt), and d SHALL equal the wdata slice selected by gnt; both are combinational from registered gnt. d SHALL be zero when gnt is zero.
REQ-019 Latency: req high at rising edge k -> gnt/en high during cycle k..k+1 -> shared register updated at edge k+1.
REQ-020 In GRANT, if req[gnt_id] and lock[gnt_id] are both high and burst count < MAXBURST, the block SHALL remain in GRANT and increment the burst count; each extra cycle is one extra write.
REQ-021 Otherwise, at the end of a GRANT cycle the block SHALL clear gnt, set ptr to (gnt_id+1) mod NREQ, and return to IDLE. This gives a mandatory single idle cycle between grants.
REQ-022 A grant, once issued, SHALL NOT be withdrawn when req drops; the write in that cycle still occurs.
REQ-023 After exactly MAXBURST consecutive writes the grant SHALL release regardless of lock.
REQ-024 With MAXBURST=1, lock SHALL have no effect.
REQ-025 gnt SHALL never have more than one bit set. en SHALL never be high in IDLE.
REQ-026 req changes arriving during GRANT SHALL be considered only at the next IDLE arbitration.
REQ-027 gnt_id SHALL hold its last value while in IDLE.

Reset
REQ-028 reset_n low SHALL immediately (asynchronously) force: state IDLE, gnt=0, en=0, d=0, busy=0, gnt_id=0, ptr=0, burst count=0.
REQ-029 reset_n low mid-burst SHALL abort the burst with no further en pulse. The first arbitration after reset_n rises SHALL start from ptr=0.

Verification
REQ-030 Setup: WIDTH=8, NREQ=4, MAXBURST=4. Release reset; raise req=0100 with wdata[2]=0xA5 -> next cycle gnt=0100, gnt_id=2, en=1, d=0xA5, busy=1 for exactly one cycle, then IDLE.
REQ-031 Hold req=1111, lock=0 -> grants in order 0,1,2,3,0. Each grant is one en cycle followed by one idle cycle.
REQ-032 req[1] and lock[1] held -> en high 4 consecutive cycles with gnt=0010, then forced release. With req=1111, the next grant is requester 2.
REQ-033 During the second burst cycle, drive reset_n low -> gnt=0 and en=0 without waiting for a clock edge. After release with req=1111, the first grant is requester 0.
REQ-034 Grant requester 3, then hold req=1001 -> next grant is requester 0 (wrap-around), then requester 3.
REQ-035 Drop req[0] in the cycle gnt=0001 -> the write still occurs (en=1, d=wdata[0]), and the burst ends even if lock[0]=1.
